uart_tx_ctrl: RTL and testbench

//  Frame sequencer for the UART transmit path. It latches a parallel word on

---
 rtl/uart_tx_ctrl_if.sv | 37 +++
 rtl/uart_tx_ctrl.sv | 154 +++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl_if
//   Bundle between the UART TX frame sequencer and its user / output mux.
//   master : drives the payload request and reads the mux controls.
//   slave  : the sequencer itself.
// Signals
//   p_data      payload word, sampled only when a frame is accepted
//   data_valid  send request (level)
//   par_en      insert a parity bit in this frame
//   par_typ     0 = even parity, 1 = odd parity
//   mux_sel     TX output mux select (00=0, 01=ser_data, 10=par_bit, 11=1)
//   ser_data    current payload bit
//   par_bit     parity bit of the frame in flight
//   busy        frame in progress
// ----------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [1:0]            mux_sel;
    logic                  ser_data;
    logic                  par_bit;
    logic                  busy;

    modport master (
        output p_data, data_valid, par_en, par_typ,
        input  mux_sel, ser_data, par_bit, busy
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ,
        output mux_sel, ser_data, par_bit, busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// uart_tx_ctrl
//   Frame sequencer for the UART transmit path. clk is the baud tick: every
//   rising edge is one bit time. A word is latched when data_valid is seen in
//   IDLE (or at the close of the final stop bit, giving back-to-back frames),
//   then the output mux is walked through START, DATA (LSB first), optional
//   PARITY and STOP_BITS stop cycles. All outputs are registered and change
//   together with the state register.
// Ports
//   clk   in   baud-tick clock
//   rst   in   asynchronous active-low reset
//   bus   slave modport of uart_tx_ctrl_if (payload request in, mux controls out)
// Parameters
//   DATA_WIDTH  payload bits per frame (5..9)
//   STOP_BITS   stop-bit cycles per frame (1 or 2)
// ----------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_DATA  = 2'b01;
    localparam logic [1:0] SEL_PAR   = 2'b10;
    localparam logic [1:0] SEL_HIGH  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_r;
    logic                  par_en_r;
    logic [1:0]            mux_sel_r;
    logic                  ser_data_r;
    logic                  par_bit_r;
    logic                  busy_r;
    logic                  accept_s;

    // Parity over the payload; odd parity is the inverse of even parity.
    function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] data,
                                          input logic                  odd);
        return (^data) ^ odd;
    endfunction

    // A word is taken when idle, or at the edge that ends the last stop cycle.
    always_comb begin
        accept_s = 1'b0;
        if (bus.data_valid) begin
            if (state_r == ST_IDLE) begin
                accept_s = 1'b1;
            end else if ((state_r == ST_STOP) && (cnt_r == STOP_LAST)) begin
                accept_s = 1'b1;
            end else begin
                accept_s = 1'b0;
            end
        end else begin
            accept_s = 1'b0;
        end
    end

    // Frame FSM; outputs are loaded alongside the next state so they are Moore-registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            cnt_r      <= '0;
            par_en_r   <= 1'b0;
            mux_sel_r  <= SEL_HIGH;
            ser_data_r <= 1'b0;
            par_bit_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else if (accept_s) begin
            shift_r    <= bus.p_data;
            par_en_r   <= bus.par_en;
            par_bit_r  <= frame_parity(bus.p_data, bus.par_typ);
            cnt_r      <= '0;
            state_r    <= ST_START;
            mux_sel_r  <= SEL_START;
            busy_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mux_sel_r <= SEL_HIGH;
                    busy_r    <= 1'b0;
                end
                ST_START: begin
                    // First payload bit is presented as DATA begins.
                    ser_data_r <= shift_r[0];
                    shift_r    <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                    cnt_r      <= '0;
                    state_r    <= ST_DATA;
                    mux_sel_r  <= SEL_DATA;
                end
                ST_DATA: begin
                    if (cnt_r == DATA_LAST) begin
                        cnt_r <= '0;
                        if (par_en_r) begin
                            state_r   <= ST_PARITY;
                            mux_sel_r <= SEL_PAR;
                        end else begin
                            state_r   <= ST_STOP;
                            mux_sel_r <= SEL_HIGH;
                        end
                    end else begin
                        cnt_r      <= cnt_r + CNT_ONE;
                        ser_data_r <= shift_r[0];
                        shift_r    <= {1'b0, shift_r[DATA_WIDTH-1:1]};
                    end
                end
                ST_PARITY: begin
                    cnt_r     <= '0;
                    state_r   <= ST_STOP;
                    mux_sel_r <= SEL_HIGH;
                end
                ST_STOP: begin
                    if (cnt_r == STOP_LAST) begin
                        cnt_r     <= '0;
                        state_r   <= ST_IDLE;
                        mux_sel_r <= SEL_HIGH;
                        busy_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // Unused encodings fall back to an idle, high line.
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    mux_sel_r <= SEL_HIGH;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mux_sel  = mux_sel_r;
    assign bus.ser_data = ser_data_r;
    assign bus.par_bit  = par_bit_r;
    assign bus.busy     = busy_r;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Two sequencers (STOP_BITS = 1 and 2) share one stimulus stream. A
//   frame-level reference model pushes the expected frame when a word is
//   accepted; a monitor reconstructs frames from the mux controls and pops
//   and compares them.
// ----------------------------------------------------------------------------
module tb_uart_tx_ctrl;
    localparam int DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          has_par;
        logic          par;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] pd  = '0;
    logic          dv  = 1'b0;
    logic          pe  = 1'b0;
    logic          pt  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int SB = g + 1;

        uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();
        assign bus.p_data     = pd;
        assign bus.data_valid = dv;
        assign bus.par_en     = pe;
        assign bus.par_typ    = pt;

        uart_tx_ctrl #(.DATA_WIDTH(DW), .STOP_BITS(SB)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        frame_t        exp_q[$];
        int            rem = 0;          // bit times left in the modelled frame
        int            frames_seen = 0;
        logic [DW-1:0] cap_d;
        logic          cap_pb;
        int            nbits, npar, nstop, nbusy;
        bit            in_frame = 1'b0;

        // Reference model: a frame is a fixed number of bit times; a request
        // is honoured only when idle or in the final bit time of a frame.
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                rem <= 0;
                exp_q.delete();
            end else if (dv && rem <= 1) begin
                exp_q.push_back('{pd, pe, 1'(($countones(pd) + int'(pt)) % 2)});
                rem <= 1 + DW + (pe ? 1 : 0) + SB;
            end else if (rem > 0) begin
                rem <= rem - 1;
            end
        end

        task automatic close_frame();
            frame_t e;
            frames_seen++;
            check($sformatf("frame_expected_sb%0d", SB), 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("payload_sb%0d", SB), 32'(cap_d), 32'(e.data));
                check($sformatf("par_bit_sb%0d", SB), 32'(cap_pb), 32'(e.par));
                check($sformatf("par_cycles_sb%0d", SB), npar, 32'(e.has_par));
                check($sformatf("data_cycles_sb%0d", SB), nbits, DW);
                check($sformatf("stop_cycles_sb%0d", SB), nstop, SB);
                check($sformatf("busy_cycles_sb%0d", SB), nbusy, 1 + DW + int'(e.has_par) + SB);
            end
        endtask

        // Monitor: rebuild each frame from the mux controls seen mid-cycle.
        always @(negedge clk) begin
            if (!rst) begin
                in_frame = 1'b0;
            end else begin
                check($sformatf("busy_sb%0d", SB), 32'(bus.busy), 32'(rem > 0));
                if (rem == 0) check($sformatf("idle_line_sb%0d", SB), 32'(bus.mux_sel), 32'd3);
                if (bus.busy && bus.mux_sel == 2'b00) begin
                    if (in_frame) close_frame();
                    in_frame = 1'b1;
                    cap_d    = '0;
                    cap_pb   = bus.par_bit;
                    nbits    = 0;
                    npar     = 0;
                    nstop    = 0;
                    nbusy    = 1;
                end else if (in_frame) begin
                    if (!bus.busy) begin
                        close_frame();
                        in_frame = 1'b0;
                    end else begin
                        nbusy++;
                        case (bus.mux_sel)
                            2'b01: begin
                                if (nbits < DW) cap_d[nbits] = bus.ser_data;
                                nbits++;
                            end
                            2'b10:   npar++;
                            default: nstop++;
                        endcase
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux_sb1"}, 32'(gen_dut[0].bus.mux_sel),  32'd3);
        check({tag, "_busy_sb1"}, 32'(gen_dut[0].bus.busy),    32'd0);
        check({tag, "_ser_sb1"}, 32'(gen_dut[0].bus.ser_data), 32'd0);
        check({tag, "_par_sb1"}, 32'(gen_dut[0].bus.par_bit),  32'd0);
        check({tag, "_mux_sb2"}, 32'(gen_dut[1].bus.mux_sel),  32'd3);
        check({tag, "_busy_sb2"}, 32'(gen_dut[1].bus.busy),    32'd0);
        check({tag, "_ser_sb2"}, 32'(gen_dut[1].bus.ser_data), 32'd0);
        check({tag, "_par_sb2"}, 32'(gen_dut[1].bus.par_bit),  32'd0);
    endtask

    task automatic scramble();
        pd = DW'($urandom);
        pe = 1'($urandom);
        pt = 1'($urandom);
    endtask

    // One-cycle request; inputs are scrambled once the word has been taken.
    task automatic send(input logic [DW-1:0] d, input logic p_en, input logic p_typ);
        @(negedge clk);
        pd = d;
        pe = p_en;
        pt = p_typ;
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        scramble();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;

        // Reset held with random inputs, then released with no request.
        repeat (4) begin
            @(negedge clk);
            scramble();
            dv = 1'($urandom);
            #1;
            check_reset_outputs("reset_hold");
        end
        @(negedge clk);
        dv = 1'b0;
        #1 rst = 1'b1;
        idle(5);

        // Plain frames, then even and odd parity.
        send(8'hA5, 1'b0, 1'b0);
        idle(14);
        send(8'hA5, 1'b1, 1'b0);
        idle(14);
        send(8'hA5, 1'b1, 1'b1);
        idle(14);

        // Request held high across the frame end: back-to-back frames.
        @(negedge clk);
        pd = 8'h3C; pe = 1'b0; pt = 1'b0; dv = 1'b1;
        @(negedge clk);
        pd = 8'hC3;
        repeat (11) @(negedge clk);
        dv = 1'b0;
        idle(25);

        // Request mid-DATA with a different word is ignored.
        send(8'h0F, 1'b0, 1'b0);
        idle(3);
        pd = 8'hFF; pe = 1'b1; dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        idle(15);

        // Reset in the 4th DATA cycle, then a clean frame.
        send(8'h5A, 1'b0, 1'b0);
        idle(4);
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_mid");
        @(negedge clk);
        #1 rst = 1'b1;
        send(8'h5A, 1'b0, 1'b0);
        idle(15);

        // Random traffic: sparse pulses and occasional long holds.
        repeat (900) begin
            @(negedge clk);
            scramble();
            dv = ($urandom_range(0, 3) == 0) ? 1'b1 : (dv && ($urandom_range(0, 7) != 0));
        end
        @(negedge clk);
        dv = 1'b0;

        n = 0;
        while ((gen_dut[0].bus.busy || gen_dut[1].bus.busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_within_bound", 32'(n < 40), 32'd1);
        idle(2);
        check("pending_frames_sb1", gen_dut[0].exp_q.size(), 32'd0);
        check("pending_frames_sb2", gen_dut[1].exp_q.size(), 32'd0);
        check("frames_observed_sb1", 32'(gen_dut[0].frames_seen > 8), 32'd1);
        check("frames_observed_sb2", 32'(gen_dut[1].frames_seen > 8), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
